quad_sample_sched: RTL and testbench

Periodic sampling scheduler for the quadrature position counter. Latches the 8-bit decoder count on a programmable sample interval. Computes the per-interval signed displacement and queues samples in a small FIFO, which the graph/display logic drains through a valid/ready handshake. It is the sole consumer of the decoder count and decides when it is observed.

---
 rtl/quad_sample_sched.sv | 128 ++++++++++++
 tb/tb_quad_sample_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/quad_sample_sched.sv
// Periodic quadrature-count sampler with FWFT sample FIFO.
// Define QUAD_SCHED_DELTA_EN for signed per-interval deltas; raw pos otherwise.
module quad_sample_sched #(
    parameter int DEPTH = 16,
    parameter int PW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [PW-1:0]            period,
    input  logic [7:0]               pos,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   P_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   P_FULL = (AW+1)'(DEPTH);
    localparam logic [PW-1:0] T_ONE  = PW'(1);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_timer;
    logic [7:0]    r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [7:0]    r_last;
    logic          r_ovf;
    logic          w_tick;
    logic          w_full;
    logic          w_pop;
    logic          w_push_ok;
    logic [7:0]    w_sample;

    assign w_tick = enable && !clear && (r_state != IDLE)
                    && (r_timer == period);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = enable ? ARM : IDLE;
        end else if (!enable) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    w_next = ARM;
                ARM:     w_next = w_tick ? RUN : ARM;
                default: w_next = RUN;
            endcase
        end
    end

    // Timer wraps naturally past 2^PW-1 when period shrinks below it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_timer <= '0;
        else if (clear || !enable || r_state == IDLE || w_tick)
            r_timer <= '0;
        else
            r_timer <= r_timer + T_ONE;
    end

`ifdef QUAD_SCHED_DELTA_EN
    logic [7:0] r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_prev <= '0;
        else if (w_tick) r_prev <= pos;
    end

    // First sample after arming has no valid reference, so it reads 0.
    assign w_sample = (r_state == ARM) ? 8'h00 : pos - r_prev;
`else
    assign w_sample = pos;
`endif

    assign level     = r_wptr - r_rptr;
    assign out_valid = (level != '0);
    assign w_full    = (level == P_FULL);
    assign w_pop     = out_valid && out_ready;
    assign w_push_ok = w_tick && (!w_full || w_pop);
    assign overflow  = r_ovf;
    assign out_data  = out_valid ? r_mem[r_rptr[AW-1:0]] : r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + P_ONE;
            if (w_pop)     r_rptr <= r_rptr + P_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= w_sample;
    end

    // Remember the visible head so out_data holds once the FIFO empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_last <= '0;
        else if (out_valid) r_last <= r_mem[r_rptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ovf <= 1'b0;
        else if (clear)
            r_ovf <= 1'b0;
        else if (w_tick && w_full && !w_pop)
            r_ovf <= 1'b1;
    end

endmodule

// File: tb/tb_quad_sample_sched.sv
// Directed bench for quad_sample_sched (delta or raw build).
// Expected values follow QUAD_SCHED_DELTA_EN when it is defined.
module tb_quad_sample_sched;

`ifdef QUAD_SCHED_DELTA_EN
    localparam bit DELTA = 1'b1;
`else
    localparam bit DELTA = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic [15:0] period;
    logic [7:0]  pos;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  level;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    logic [7:0] p   [17];
    logic [7:0] exq [17];
    logic [7:0] ev;

    quad_sample_sched #(.DEPTH(16), .PW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clear     (clear),
        .period    (period),
        .pos       (pos),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] smp(input logic [7:0] cur,
                                       input logic [7:0] prv,
                                       input bit first);
        if (!DELTA) return cur;
        if (first)  return 8'h00;
        return cur - prv;
    endfunction

    initial begin
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
        period = 16'd0; pos = 8'h00; out_ready = 1'b0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'h00);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        step;
        rst_n = 1'b1;
        step;

        // basic cadence, period=3
        enable = 1'b1; period = 16'd3; pos = 8'h20; out_ready = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step;
            chk($sformatf("cad_valid_%0d", k), 32'(out_valid),
                32'((k >= 5) && (k % 4 == 1)));
            if ((k >= 5) && (k % 4 == 1))
                chk($sformatf("cad_data_%0d", k), 32'(out_data),
                    32'(smp(8'h20, 8'h20, k == 5)));
        end

        // delta wrap
        clear = 1'b1; enable = 1'b0;
        step;
        clear = 1'b0;
        period = 16'd0; out_ready = 1'b0; pos = 8'hFA; enable = 1'b1;
        step;
        step;
        pos = 8'h04;
        step;
        pos = 8'hFA;
        step;
        enable = 1'b0;
        chk("wrap_level", 32'(level), 32'd3);
        chk("wrap_d0", 32'(out_data), 32'(smp(8'hFA, 8'h00, 1)));
        out_ready = 1'b1;
        step;
        chk("wrap_d1", 32'(out_data), 32'(smp(8'h04, 8'hFA, 0)));
        step;
        chk("wrap_d2", 32'(out_data), 32'(smp(8'hFA, 8'h04, 0)));
        step;
        chk("wrap_empty", 32'(out_valid), 32'd0);
        chk("wrap_hold", 32'(out_data), 32'(smp(8'hFA, 8'h04, 0)));
        out_ready = 1'b0;

        // overflow, period=0
        pos = 8'h10; enable = 1'b1;
        for (int k = 0; k < 17; k++) step;
        chk("ovf_full_level", 32'(level), 32'd16);
        chk("ovf_pre", 32'(overflow), 32'd0);
        pos = 8'h30;
        step;
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd16);
        pos = 8'h35; out_ready = 1'b1;
        step;
        chk("ovf_pushpop_level", 32'(level), 32'd16);
        enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ev = (i == 15) ? smp(8'h35, 8'h30, 0) : smp(8'h10, 8'h10, 0);
            chk($sformatf("ovf_drain_%0d", i), 32'(out_data), 32'(ev));
            step;
        end
        chk("ovf_drained", 32'(level), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // full with simultaneous push and pop
        clear = 1'b1;
        step;
        clear = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        out_ready = 1'b0; enable = 1'b1;
        for (int i = 0; i < 17; i++) p[i] = 8'(i * i * 5 + 8'h40);
        exq[0] = smp(p[0], 8'h00, 1);
        for (int i = 1; i < 17; i++) exq[i] = smp(p[i], p[i-1], 0);
        step;
        for (int i = 0; i < 16; i++) begin
            pos = p[i];
            step;
        end
        chk("pp_fill", 32'(level), 32'd16);
        pos = p[16]; out_ready = 1'b1;
        step;
        chk("pp_level", 32'(level), 32'd16);
        chk("pp_ovf", 32'(overflow), 32'd0);
        enable = 1'b0;
        for (int i = 1; i < 17; i++) begin
            chk($sformatf("pp_order_%0d", i), 32'(out_data), 32'(exq[i]));
            step;
        end
        chk("pp_empty", 32'(out_valid), 32'd0);

        // clear mid-RUN with coincident tick
        out_ready = 1'b0; period = 16'd3; pos = 8'h50; enable = 1'b1;
        for (int k = 0; k < 24; k++) step;
        chk("clr_pre_level", 32'(level), 32'd5);
        clear = 1'b1; pos = 8'h60;
        step;
        clear = 1'b0;
        chk("clr_level", 32'(level), 32'd0);
        chk("clr_valid", 32'(out_valid), 32'd0);
        chk("clr_ovf2", 32'(overflow), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step;
            chk($sformatf("clr_next_%0d", k), 32'(out_valid),
                32'(k == 4));
        end
        chk("clr_first", 32'(out_data), 32'(smp(8'h60, 8'h50, 1)));

        // async reset mid-RUN
        for (int k = 0; k < 4; k++) step;
        chk("ar_pre_level", 32'(level), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_level", 32'(level), 32'd0);
        chk("ar_data", 32'(out_data), 32'h00);
        chk("ar_ovf", 32'(overflow), 32'd0);
        step;
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step;
            chk($sformatf("ar_restart_%0d", k), 32'(out_valid),
                32'(k == 5));
        end
        chk("ar_first", 32'(out_data), 32'(smp(8'h60, 8'h60, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
